// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the iterative RV32M divider.
//   - div_op_e    : operation encoding as presented on in_op
//   - div_state_e : control FSM states
//   - DIV_ITERS, DIV_LATENCY, special-result constants
//   - helpers to decode the op and to build the forced special results
package div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP_A,
        S_PREP_B,
        S_ITER,
        S_FIX,
        S_DONE
    } div_state_e;

    localparam int          DIV_ITERS     = 32;
    localparam int          DIV_LATENCY   = 36;
    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_OVF_Q     = 32'h8000_0000;

    // DIV/REM are signed (op[0]=0), REM/REMU return the remainder (op[1]=1).
    function automatic logic op_is_signed(div_op_e op);
        return !op[0];
    endfunction

    function automatic logic op_is_rem(div_op_e op);
        return op[1];
    endfunction

    // Result for divide-by-zero or signed overflow (0x80000000 / -1).
    function automatic logic [31:0] special_result(logic is_rem, logic div_zero,
                                                   logic [31:0] dividend);
        if (div_zero) return is_rem ? dividend : DIV_BY_ZERO_Q;
        return is_rem ? 32'h0 : DIV_OVF_Q;
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: combinational single restoring-division step.
//   rem_i, quo_i   : current partial remainder R and quotient/dividend shifter Q
//   div_i          : divisor magnitude D
//   add_sum_i      : shared adder result for the operands driven below
//   rem_o, quo_o   : R and Q after this step
//   ge_o           : 33-bit compare {R, Q[MSB]} >= D
//   add_a_o/add_b_o/add_sel_o : adder operands computing R' - D
module div_step
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] div_i,
    input  logic [XLEN-1:0] add_sum_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o,
    output logic            ge_o,
    output logic [XLEN-1:0] add_a_o,
    output logic [XLEN-1:0] add_b_o,
    output logic            add_sel_o
);

    // Shifted remainder keeps a 33rd bit so a remainder close to 2^32 still
    // compares correctly against a large divisor.
    logic [XLEN:0] r_shift;

    assign r_shift   = {rem_i, quo_i[XLEN-1]};
    assign ge_o      = (r_shift >= {1'b0, div_i});

    // R' - D via A + ~D + 1; only meaningful (and only used) when ge_o holds,
    // in which case the difference is below D and fits in XLEN bits.
    assign add_a_o   = r_shift[XLEN-1:0];
    assign add_b_o   = ~div_i;
    assign add_sel_o = 1'b1;

    assign rem_o     = ge_o ? add_sum_i : r_shift[XLEN-1:0];
    assign quo_o     = {quo_i[XLEN-2:0], ge_o};

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative 32-bit RV32M divider (DIV, DIVU, REM, REMU).
// Shares an external add/sub unit: drives add_a/add_b/add_sel and consumes
// add_sum in the same cycle for operand negation, trial subtraction and the
// final sign fix-up.
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid/in_ready         : request handshake, in_op/in_a/in_b operands
//   out_valid/out_ready       : result handshake, out_result
//   add_a/add_b/add_sel       : shared adder operands (0 when unused)
//   add_sum                   : shared adder result
// Build option: DIV_SPECIAL_FASTPATH_EN sends divide-by-zero and signed
// overflow requests from IDLE straight to DONE.
module div_unit
    import div_pkg::*;
#(
    parameter int XLEN = 32  // only 32 is supported
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] add_a,
    output logic [XLEN-1:0] add_b,
    output logic            add_sel,
    input  logic [XLEN-1:0] add_sum
);

    div_state_e      state_q, state_d;
    div_op_e         op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;        // original dividend, for div-by-zero REM
    logic [XLEN-1:0] quo_q, quo_d;    // |dividend| shifting out, quotient in
    logic [XLEN-1:0] div_q, div_d;    // |divisor|
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic            zero_q, zero_d, ovf_q, ovf_d;
    logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d;

    logic [XLEN-1:0] step_rem, step_quo, step_add_a, step_add_b;
    logic            step_add_sel, step_ge_unused;
    logic [XLEN-1:0] fix_val;
    logic            fix_neg;
    div_op_e         req_op;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .div_i     (div_q),
        .add_sum_i (add_sum),
        .rem_o     (step_rem),
        .quo_o     (step_quo),
        .ge_o      (step_ge_unused),  // already folded into step_rem/step_quo
        .add_a_o   (step_add_a),
        .add_b_o   (step_add_b),
        .add_sel_o (step_add_sel)
    );

    assign req_op  = div_op_e'(in_op);

    // Only the selected result needs a sign fix, so one adder pass suffices.
    assign fix_val = op_is_rem(op_q) ? rem_q : quo_q;
    assign fix_neg = op_is_rem(op_q) ? neg_a_q : (neg_a_q ^ neg_b_q);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        quo_d    = quo_q;
        div_d    = div_q;
        rem_d    = rem_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        add_a    = '0;
        add_b    = '0;
        add_sel  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    op_d    = req_op;
                    a_d     = in_a;
                    quo_d   = in_a;
                    div_d   = in_b;
                    neg_a_d = op_is_signed(req_op) && in_a[XLEN-1];
                    neg_b_d = op_is_signed(req_op) && in_b[XLEN-1];
                    zero_d  = (in_b == '0);
                    ovf_d   = op_is_signed(req_op) && (in_a == DIV_OVF_Q) && (in_b == '1);
                    state_d = S_PREP_A;
`ifdef DIV_SPECIAL_FASTPATH_EN
                    if (zero_d || ovf_d) begin
                        result_d = special_result(op_is_rem(req_op), zero_d, in_a);
                        state_d  = S_DONE;
                    end
`endif
                end
            end
            S_PREP_A: begin
                add_b   = ~quo_q;
                add_sel = 1'b1;
                if (neg_a_q) quo_d = add_sum;
                state_d = S_PREP_B;
            end
            S_PREP_B: begin
                add_b   = ~div_q;
                add_sel = 1'b1;
                if (neg_b_q) div_d = add_sum;
                rem_d   = '0;
                cnt_d   = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                add_a   = step_add_a;
                add_b   = step_add_b;
                add_sel = step_add_sel;
                rem_d   = step_rem;
                quo_d   = step_quo;
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'(DIV_ITERS - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                add_b   = ~fix_val;
                add_sel = 1'b1;
                if (zero_q || ovf_q) result_d = special_result(op_is_rem(op_q), zero_q, a_q);
                else                 result_d = fix_neg ? add_sum : fix_val;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only control and visible outputs are reset; datapath registers are always loaded before use.
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
        op_q    <= op_d;
        a_q     <= a_d;
        quo_q   <= quo_d;
        div_q   <= div_d;
        rem_q   <= rem_d;
        cnt_q   <= cnt_d;
        neg_a_q <= neg_a_d;
        neg_b_q <= neg_b_d;
        zero_q  <= zero_d;
        ovf_q   <= ovf_d;
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = result_q;

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit RV32M divider (DIV, DIVU, REM, REMU) in the EX stage, downstream of operand selection and wrapped around the shared 32-bit add/sub datapath. It drives that unit's A, B and sel inputs each cycle and consumes its 32-bit sum for operand negation, restoring-division trial subtraction and result sign fix-up. It exchanges operands and results with the pipeline over valid/ready handshakes.

## Interface
- `XLEN`, default 32: operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  request valid
- `in_ready`  out  1  block can accept a request; high only in IDLE
- `in_op`  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- `in_a`  in  32  dividend (rs1)
- `in_b`  in  32  divisor (rs2)
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts the result
- `out_result`  out  32  quotient (DIV/DIVU) or remainder (REM/REMU)
- `add_a`  out  32  add/sub operand A
- `add_b`  out  32  add/sub operand B; the block pre-inverts it for subtraction
- `add_sel`  out  1  add/sub carry-in: 1 = subtract/negate
- `add_sum`  in  32  add/sub result, combinational from the three outputs above

## Operation
- States: IDLE, PREP_A, PREP_B, ITER, FIX, DONE.
- Signed ops (DIV, REM): record the sign of each operand.
- Negation: `add_a`=0, `add_b`=~x, `add_sel`=1, result taken from `add_sum`.
- IDLE: when `in_valid` and `in_ready` are both high, latch op and operands, then go to PREP_A.
- PREP_A: if signed and the dividend is negative, load |dividend| from `add_sum`; otherwise pass it through unchanged. Go to PREP_B.
- PREP_B: same handling for the divisor. Clear the remainder to 0, clear the counter to 0, go to ITER.
- ITER, one restoring step per cycle:
  - R' = {R[30:0], Q[31]} with the 33rd bit kept internally.
  - Drive `add_a`=R'[31:0], `add_b`=~D, `add_sel`=1.
  - If the 33-bit compare R' ≥ D holds, R ← `add_sum` and the Q LSB is 1; otherwise R ← R' and the Q LSB is 0.
  - Q shifts left each step. Counter counts 0..31; after 31, go to FIX.
- FIX: for signed ops, negate Q when the operand signs differ and negate R when the dividend is negative, using the adder. Select Q or R by op.
- FIX also forces the special results:
  - Divisor 0: quotient 0xFFFFFFFF, remainder = original dividend.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- FIX writes `out_result` and goes to DONE.
- DONE: hold `out_valid` and `out_result` stable until `out_ready` is high, then go to IDLE.
- Outside PREP_A, PREP_B, ITER and FIX, `add_a`, `add_b` and `add_sel` are 0.
- `rst` in any state: go to IDLE, abandon the operation, emit no result.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_result`=0, `add_a`/`add_b`=0, `add_sel`=0, state IDLE.
- Fixed latency: request accepted at edge 0 → `out_valid` high after edge 36 (2 prep + 32 iterate + 1 fix + DONE entry).
- `in_ready`=0 from the accept edge until DONE exits. A new request can be accepted the cycle after the result handshake.
- `out_ready` held low: stay in DONE indefinitely with outputs stable.
- `in_valid` while busy: ignored, no side effects.

## Configuration
- `DIV_SPECIAL_FASTPATH_EN` defined: divisor-zero and signed-overflow requests bypass PREP, ITER and FIX and go from IDLE straight to DONE. `out_valid` rises 1 cycle after accept, with the same special values.
- Not defined: every request takes 36 cycles; special values are forced in FIX.

## Structure
- `div_pkg`:
  - op enum (DIV, DIVU, REM, REMU)
  - state enum
  - `DIV_ITERS`=32
  - `DIV_LATENCY`=36
  - special-value constants `DIV_BY_ZERO_Q`=32'hFFFFFFFF and `DIV_OVF_Q`=32'h80000000
- Sub-module `div_step`: combinational one-step logic taking {R, Q, D, `add_sum`} and producing {R_next, Q_next, the 33-bit compare, adder operands}.

## Test plan
- DIVU 100/7 → 14 after 36 cycles; REMU 100/7 → 2.
- DIV -7/2 (0xFFFFFFF9, 2) → 0xFFFFFFFD (-3); REM -7/2 → 0xFFFFFFFF (-1).
- DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5. Latency 36, or 1 with `DIV_SPECIAL_FASTPATH_EN`.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Hold `out_ready` low 10 cycles after the result → `out_result` stable, `in_ready`=0, and a concurrent `in_valid` is not accepted.
- Assert `rst` at iteration 15 → next cycle `in_ready`=1 and `out_valid`=0; a fresh DIVU 9/3 then returns 3.
